// File: rtl/add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : add_ctrl_pkg
//  Description : State encoding and sizing helper for the slice-serial adder.
//  Revision    : 1.0 - initial release
// ============================================================================
package add_ctrl_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Slice index width; a single-slice build still needs one bit.
    function automatic int idx_width(input int nslice);
        int w;
        w = $clog2(nslice);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/slice_adder.sv
`default_nettype none
// ============================================================================
//  Module      : slice_adder
//  Description : SLICE-bit combinational ripple-carry adder built from
//                full-adder cells; also exposes the carry into the MSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module slice_adder #(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_fa
        assign s[i]     = x[i] ^ y[i] ^ w_c[i];
        assign w_c[i+1] = (x[i] & y[i]) | (w_c[i] & (x[i] ^ y[i]));
    end

    assign cout = w_c[SLICE];
    assign cmsb = w_c[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/seq_add_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seq_add_ctrl
//  Description : Add/subtract sequencer that computes a WIDTH-bit result one
//                SLICE-bit slice per cycle on a single shared slice adder.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_add_ctrl #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    import add_ctrl_pkg::*;

    localparam int NSLICE = (SLICE > 0) ? (WIDTH / SLICE) : 1;
    localparam int IW     = idx_width(NSLICE);
    localparam logic [IW-1:0] c_last_idx = IW'(NSLICE - 1);

    if ((SLICE == 0) || ((WIDTH % ((SLICE == 0) ? 1 : SLICE)) != 0)) begin : g_param_check
        $error("seq_add_ctrl: WIDTH must be a nonzero multiple of SLICE");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_partial;
    logic             r_carry;
    logic [IW-1:0]    r_idx;

    logic             w_capture;
    logic             w_last;
    int               w_base;
    logic [SLICE-1:0] w_x;
    logic [SLICE-1:0] w_y;
    logic [SLICE-1:0] w_s;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_last      = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_capture   = start;
                w_state_nxt = start ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                busy   = 1'b1;
                w_last = (r_idx == c_last_idx);
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done        = 1'b1;
                w_capture   = start;
                w_state_nxt = start ? ST_RUN : ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Slice mux in, and the partial result with the current slice merged in.
    always_comb begin
        w_base = int'(r_idx) * SLICE;
        w_x    = r_op_a[w_base +: SLICE];
        w_y    = r_op_b[w_base +: SLICE];
        w_full = r_partial;
        w_full[w_base +: SLICE] = w_s;
    end

    slice_adder #(
        .SLICE (SLICE)
    ) u_slice_adder (
        .x    (w_x),
        .y    (w_y),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout),
        .cmsb (w_cmsb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_idx     <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            ovf       <= 1'b0;
        end else if (w_capture) begin
            r_op_a  <= a;
            r_op_b  <= sub ? ~b : b;
            r_carry <= sub;
            r_idx   <= '0;
        end else if (r_state == ST_RUN) begin
            r_partial <= w_full;
            r_carry   <= w_cout;
            r_idx     <= w_last ? '0 : r_idx + IW'(1);
            if (w_last) begin
                sum   <= w_full;
                c_out <= w_cout;
                ovf   <= w_cmsb ^ w_cout;
            end
        end
    end

endmodule
`default_nettype wire
